medicine_uart_rx: RTL
=====================

// Module: medicine_uart_rx
// PURPOSE
//  UART receiver (8N1) that decodes the serial stream produced on the medicine controller's txd pin.
//  It is the far end of that link: a PC-side/bench-side decoder and loop-back checker for dose/alarm reports.
//  It oversamples the line, validates the start and stop bits, and presents each byte on a valid/ready
//  holding register. It flags framing and overrun errors.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per bit (50 MHz / 115200); must be >= 4; benches use 8
//  DATA_BITS     8    data bits per frame, sent LSB first; fixed at 8 for this design
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  rxd        in   1  serial input; idles high; asynchronous to clk
//  rx_data    out  8  received byte; valid while rx_valid=1
//  rx_valid   out  1  byte available; held until accepted
//  rx_ready   in   1  consumer accepts rx_data on a clk edge where rx_valid & rx_ready
//  frame_err  out  1  one-cycle pulse: stop bit sampled low
//  overrun    out  1  sticky: a completed byte was dropped because rx_valid was still high
//  clr_err    in   1  clears overrun
//  busy       out  1  high while in any state other than IDLE
// BEHAVIOUR
//  Reset: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, counters=0.
//   Both synchroniser flops reset to 1. Reset mid-frame aborts the frame silently.
//  Input path: rxd goes through a 2-flop synchroniser to give rxd_s. All decisions use rxd_s only.
//  FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. One bit counter, 0..CLKS_PER_BIT-1.
//  IDLE: on rxd_s==0, go to START and clear the counter.
//  START: when the counter reaches CLKS_PER_BIT/2-1 (mid start bit), sample rxd_s.
//   - If it is 1, this is a glitch: go to IDLE with no flag.
//   - If it is 0, clear the counter and the bit index, then go to DATA.
//  DATA: sample rxd_s when the counter reaches CLKS_PER_BIT-1 (mid bit).
//   - Shift the sample in LSB-first and clear the counter.
//   - After the 8th sample, go to STOP.
//  STOP: sample at mid stop bit (counter = CLKS_PER_BIT-1).
//   - Stop bit = 1: deliver the byte and go to IDLE immediately, without waiting for the bit end.
//     This allows back-to-back frames with zero idle gap.
//   - Stop bit = 0: frame_err=1 for one cycle, discard the byte, go to WAIT_HIGH.
//  WAIT_HIGH: stay until rxd_s==1, then go to IDLE. A held-low break is reported only once.
//  Delivery: rx_valid/rx_data update on the cycle after the stop sample.
//   - rx_valid=0, or rx_valid & rx_ready in that same cycle: load rx_data, rx_valid=1, no overrun.
//   - rx_valid=1 & !rx_ready: keep the old rx_data and set overrun=1.
//   - rx_valid clears on the cycle after a handshake, unless a new byte loads in the same cycle.
//  overrun: clr_err clears it. If a set and clr_err happen in the same cycle, set wins.
//  Latency: rx_valid rises about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clks after the falling edge of rxd.
//  The bit counter never wraps: it is cleared on every sample and on every state change.
// TESTING  (CLKS_PER_BIT=8; rx_ready=1 unless stated)
//  1. Frame 0xA5, stop=1 -> one rx_valid pulse with rx_data=0xA5; frame_err=0, overrun=0; busy falls after.
//  2. rxd low for 2 clks, then high -> no rx_valid; busy returns 0 within 6 clks; no flags.
//  3. Frame 0x3C with stop=0, line held low 3 bit times, then frame 0x11 -> one frame_err pulse,
//     no valid for 0x3C, then rx_data=0x11 valid.
//  4. rx_ready=0; frames 0x01 then 0x02 -> rx_data stays 0x01 and overrun=1.
//     Then pulse rx_ready -> rx_valid=0. Then pulse clr_err -> overrun=0.
//  5. Back-to-back 0x00 then 0xFF with no idle gap -> two valid bytes, 0x00 then 0xFF, in order, no errors.
//  6. Assert rst after 4 data bits of 0x77 -> all outputs 0 next clk.
//     Release rst and send 0x5A -> rx_data=0x5A, no errors.

Source files
------------

// File: rtl/medicine_uart_rx.sv
// 8N1 UART receiver: decodes the medicine controller's txd stream into bytes on a
// valid/ready holding register, with framing-error pulse and sticky overrun flag.
`timescale 1ns/1ps

module medicine_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err,
  output logic       busy
);

  // state     | meaning
  // IDLE      | line idle, waiting for a falling edge on rxd_s
  // START     | timing to the middle of the start bit to reject glitches
  // DATA      | sampling data bits LSB first, one per bit period
  // STOP      | sampling the stop bit; deliver or flag framing error
  // WAIT_HIGH | after a framing error, wait for the line to return high
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 rxd_meta, rxd_s;
  logic                 deliver, ferr_set;

  // Synchroniser flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxd_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_CNT) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_n     = '0;
          shift_n   = {rxd_s, shift[DATA_BITS-1:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) state_n = STOP;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a zero-gap next start edge is not missed.
        if (cnt == LAST_CNT) begin
          cnt_n = '0;
          if (rxd_s) begin
            deliver = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rxd_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // A new overrun in the same cycle as clr_err keeps the flag set.
      if (deliver && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (clr_err)                     overrun <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule
